// File: rtl/nor_xor_pkg.sv
// Shared types and helpers for the 4-bit XOR/NOR nibble scrambler and its decoder.
package nor_xor_pkg;

   localparam int unsigned NIBBLE_W = 4;
   localparam int unsigned STEP_W   = 2;
   localparam int unsigned RND_W    = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S1   = 3'd1,
      S2   = 3'd2,
      S3   = 3'd3,
      S4   = 3'd4,
      HOLD = 3'd5
   } state_t;

   // One forward scrambler round, plaintext p to cipher c.
   function automatic logic [NIBBLE_W-1:0] scramble_round(input logic [NIBBLE_W-1:0] p);
      logic c3, c2, c1, c0;
      c3 = p[0] ^ ~(p[3] | p[2]);
      c2 = p[3] ^ ~(p[2] | p[1]);
      c1 = p[2] ^ ~(p[1] | c3);
      c0 = p[1] ^ ~(c3 | c2);
      return {c3, c2, c1, c0};
   endfunction

endpackage

// File: rtl/nor_xor_step.sv
// One inverse-round step: recovers a single plaintext bit from the working nibble.
module nor_xor_step
   import nor_xor_pkg::*;
(
   input  logic [NIBBLE_W-1:0] work,
   input  logic [STEP_W-1:0]   step,
   output logic [NIBBLE_W-1:0] next_work_c
);

   // Each recovered bit parks in the slot of a cipher bit that is no longer needed
   // (c0 after S1, c1 after S2, c2 after S3); S4 then lays the nibble out as p[3:0].
   always_comb begin
      next_work_c = work;
      case (step)
         2'd0: next_work_c[0] = work[0] ^ ~(work[3] | work[2]);
         2'd1: next_work_c[1] = work[1] ^ ~(work[0] | work[3]);
         2'd2: next_work_c[2] = work[2] ^ ~(work[1] | work[0]);
         2'd3: next_work_c    = {work[2], work[1], work[0], work[3] ^ ~(work[2] | work[1])};
         default: next_work_c = work;
      endcase
   end

endmodule

// File: rtl/nor_xor_nibble_decoder.sv
// Iterative decoder inverting ROUNDS cascaded XOR/NOR scrambler rounds, one bit per clock.
module nor_xor_nibble_decoder
   import nor_xor_pkg::*;
#(
   parameter int unsigned ROUNDS = 1
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NIBBLE_W-1:0] in_cipher,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NIBBLE_W-1:0] out_plain,
   output logic                busy
);

   if (ROUNDS < 1 || ROUNDS > 8) begin : g_rounds_check
      $fatal(1, "nor_xor_nibble_decoder: ROUNDS must be in 1..8");
   end

   localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

   state_t              state;
   logic [NIBBLE_W-1:0] work;
   logic [RND_W-1:0]    rnd;
   logic [STEP_W-1:0]   step_idx_c;
   logic [NIBBLE_W-1:0] step_work_c;

   always_comb begin
      step_idx_c = 2'd0;
      case (state)
         S1:      step_idx_c = 2'd0;
         S2:      step_idx_c = 2'd1;
         S3:      step_idx_c = 2'd2;
         S4:      step_idx_c = 2'd3;
         default: step_idx_c = 2'd0;
      endcase
   end

   nor_xor_step u_step (
      .work        (work),
      .step        (step_idx_c),
      .next_work_c (step_work_c)
   );

   // Control FSM; handshake outputs are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         work      <= '0;
         rnd       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work     <= in_cipher;
                  rnd      <= '0;
                  state    <= S1;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            S1: begin
               work  <= step_work_c;
               state <= S2;
            end
            S2: begin
               work  <= step_work_c;
               state <= S3;
            end
            S3: begin
               work  <= step_work_c;
               state <= S4;
            end
            S4: begin
               work <= step_work_c;
               if (rnd == LAST_RND) begin
                  state     <= HOLD;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  rnd   <= rnd + 3'd1;
                  state <= S1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_plain = work;

endmodule

// File: tb/tb_nor_xor_nibble_decoder.sv
// Bench for nor_xor_nibble_decoder: ROUNDS=1 and ROUNDS=3 instances against a search-based model.
module tb_nor_xor_nibble_decoder;
   import nor_xor_pkg::*;

   localparam int R0 = 1;
   localparam int R1 = 3;

   logic       clk;
   logic       rst_n;
   logic [1:0] in_valid;
   logic [1:0] in_ready;
   logic [3:0] in_cipher [2];
   logic [1:0] out_valid;
   logic [1:0] out_ready;
   logic [3:0] out_plain [2];
   logic [1:0] busy;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   int         m_left  [2] = '{0, 0};
   logic       m_hold  [2] = '{1'b0, 1'b0};
   logic [3:0] m_plain [2] = '{4'h0, 4'h0};

   nor_xor_nibble_decoder #(.ROUNDS(R0)) dut_r1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_cipher(in_cipher[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_plain(out_plain[0]),
      .busy(busy[0])
   );

   nor_xor_nibble_decoder #(.ROUNDS(R1)) dut_r3 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_cipher(in_cipher[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_plain(out_plain[1]),
      .busy(busy[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int rounds_of(input int i);
      return (i == 0) ? R0 : R1;
   endfunction

   function automatic logic [3:0] scramble_n(input int r, input logic [3:0] p);
      logic [3:0] t;
      t = p;
      for (int k = 0; k < r; k++) t = scramble_round(t);
      return t;
   endfunction

   // Decode by exhaustive search over plaintexts, not by stepping the inverse.
   function automatic logic [3:0] model_decode(input int r, input logic [3:0] c);
      for (int p = 0; p < 16; p++) begin
         if (scramble_n(r, 4'(p)) == c) return 4'(p);
      end
      return 4'h0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle model: a decode lasts 4*R cycles, then HOLD until out_ready.
   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_left[i] <= 0;
            m_hold[i] <= 1'b0;
         end else if (m_hold[i]) begin
            if (out_ready[i]) m_hold[i] <= 1'b0;
         end else if (m_left[i] > 0) begin
            m_left[i] <= m_left[i] - 1;
            if (m_left[i] == 1) m_hold[i] <= 1'b1;
         end else if (in_valid[i]) begin
            m_left[i]  <= 4 * rounds_of(i);
            m_plain[i] <= model_decode(rounds_of(i), in_cipher[i]);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("in_ready[%0d]", i), 32'(in_ready[i]),
                32'(!m_hold[i] && m_left[i] == 0));
            chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_left[i] > 0));
            chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(m_hold[i]));
            if (m_hold[i])
               chk($sformatf("out_plain[%0d]", i), 32'(out_plain[i]), 32'(m_plain[i]));
         end
      end
   end

   task automatic xfer(input int i, input logic [3:0] c, input logic [3:0] exp, input int stall);
      int n;
      in_cipher[i] = c;
      in_valid[i]  = 1'b1;
      out_ready[i] = (stall == 0);
      n = 0;
      while (in_ready[i] !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_wait", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      in_valid[i]  = 1'b0;
      in_cipher[i] = 4'h0;
      n = 0;
      while (out_valid[i] !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("latency[%0d]", i), 32'(n), 32'(4 * rounds_of(i)));
      chk($sformatf("plain[%0d]_%h", i, c), 32'(out_plain[i]), 32'(exp));
      if (stall > 0) begin
         repeat (stall) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid[i]), 32'd1);
            chk("bp_plain", 32'(out_plain[i]), 32'(exp));
            chk("bp_in_ready", 32'(in_ready[i]), 32'd0);
            chk("bp_busy", 32'(busy[i]), 32'd0);
         end
         out_ready[i] = 1'b1;
      end
      @(posedge clk); #1;
      out_ready[i] = 1'b0;
      chk("valid_one_cycle", 32'(out_valid[i]), 32'd0);
      chk("back_to_idle", 32'(in_ready[i]), 32'd1);
   endtask

   initial begin
      logic [3:0] c;
      rst_n     = 1'b0;
      in_valid  = 2'b00;
      out_ready = 2'b00;
      in_cipher[0] = 4'h0;
      in_cipher[1] = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
         chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
         chk("rst_busy", 32'(busy[i]), 32'd0);
         chk("rst_work", 32'(out_plain[i]), 32'd0);
      end
      rst_n  = 1'b1;
      chk_en = 1'b1;

      chk("pin_scr_0000", 32'(scramble_round(4'b0000)), 32'(4'b1100));
      chk("pin_scr_0001", 32'(scramble_round(4'b0001)), 32'(4'b0110));
      chk("pin_dec1_0101", 32'(model_decode(1, 4'b0101)), 32'(4'b1010));
      chk("pin_dec1_1111", 32'(model_decode(1, 4'b1111)), 32'(4'b1111));

      xfer(0, 4'b1100, 4'b0000, 0);
      xfer(0, 4'b0110, 4'b0001, 0);
      xfer(0, 4'b0101, 4'b1010, 0);
      xfer(0, 4'b1111, 4'b1111, 0);

      for (int p = 0; p < 16; p++) begin
         c = scramble_n(3, 4'(p));
         xfer(1, c, 4'(p), 0);
      end

      c = scramble_n(3, 4'h9);
      xfer(1, c, 4'h9, 10);

      in_cipher[0] = 4'b0110;
      in_valid[0]  = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_busy", 32'(busy[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
      chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
      chk("midrst_busy", 32'(busy[0]), 32'd0);
      chk("midrst_work", 32'(out_plain[0]), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      xfer(0, 4'b1100, 4'b0000, 0);

      repeat (20) begin
         @(posedge clk); #1;
         chk("idle_in_ready", 32'(in_ready[0]), 32'd1);
         chk("idle_busy", 32'(busy[0]), 32'd0);
         chk("idle_out_valid", 32'(out_valid[0]), 32'd0);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
